// File: rtl/spi_cmd_regfile.sv
// rtl/spi_cmd_regfile.sv - SPI frame decoder and radio control register file (optional SPI_CMD_PARITY_EN)
module spi_cmd_regfile #(
    parameter int          WIDTH       = 48,
    parameter logic [7:0]  VERSION     = 8'h24,
    parameter logic [23:0] WDOG_CYCLES = 24'd7_680_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             spi_done,
    input  logic [WIDTH-1:0] spi_rdata,
    output logic [WIDTH-1:0] spi_tdata,
    output logic [31:0]      rx1_freq,
    output logic [31:0]      rx2_freq,
    output logic [31:0]      tx_freq,
    output logic [7:0]       drive_level,
    output logic [4:0]       att,
    output logic             ptt,
    output logic [7:0]       gpio_out,
    output logic             cfg_update,
    output logic             frame_err
);
    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [2:0]  sync_q;
    logic        done_rise;
    logic [47:0] word_q;
    logic [7:0]  addr_w;
    logic        wr_w;
    logic [5:0]  seq_w;
    logic [31:0] data_w;
    logic        latch_en, in_check, in_resp;
    logic        parity_bad, frame_bad, accept, wr_en, wr_ptt, wdog_hit, status_rd;
    logic [31:0] rx1_q, rx2_q, tx_q, rd_val;
    logic [7:0]  drive_q, gpio_q;
    logic [4:0]  att_q;
    logic        ptt_q, ovr_q, wdog_trip_q, err_q, cfg_update_q, frame_err_q;
    logic [15:0] err_cnt_q;
    logic [23:0] wdog_cnt_q;
    logic [47:0] tdata_q;

    assign done_rise = sync_q[1] & ~sync_q[2];
    assign addr_w    = word_q[47:40];
    assign wr_w      = word_q[39];
    assign seq_w     = word_q[38:33];
    assign data_w    = word_q[31:0];

`ifdef SPI_CMD_PARITY_EN
    assign parity_bad = ^word_q;
`else
    logic unused_parity_bit;
    assign unused_parity_bit = word_q[32];
    assign parity_bad = 1'b0;
`endif

    assign frame_bad = (addr_w > 8'd7) | (wr_w & (addr_w == 8'd7)) | parity_bad;
    assign accept    = in_check & ~frame_bad;
    assign wr_en     = accept & wr_w;
    assign wr_ptt    = wr_en & (addr_w == 8'd5);
    assign wdog_hit  = ptt_q & (wdog_cnt_q == WDOG_CYCLES - 24'd1);
    assign status_rd = (addr_w == 8'd7) & ~wr_w & ~err_q;

    // Two-stage synchronizer on spi_done plus one delay stage for edge detection
    always_ff @(posedge clk) begin
        if (reset) sync_q <= 3'b000;
        else       sync_q <= {sync_q[1:0], spi_done};
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state: one frame walks IDLE -> CHECK -> RESP -> IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (done_rise) state_d = S_CHECK;
            S_CHECK: state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: per-state strobes used by the datapath
    always_comb begin
        latch_en = (state_q == S_IDLE) & done_rise;
        in_check = (state_q == S_CHECK);
        in_resp  = (state_q == S_RESP);
    end

    // Read mux: post-write register value, zero-extended; out-of-range reads return zero
    always_comb begin
        rd_val = 32'h0;
        case (addr_w)
            8'd0: rd_val = rx1_q;
            8'd1: rd_val = rx2_q;
            8'd2: rd_val = tx_q;
            8'd3: rd_val = {24'h0, drive_q};
            8'd4: rd_val = {27'h0, att_q};
            8'd5: rd_val = {31'h0, ptt_q};
            8'd6: rd_val = {24'h0, gpio_q};
            8'd7: rd_val = {VERSION, err_cnt_q, 6'b0, ovr_q, wdog_trip_q};
            default: rd_val = 32'h0;
        endcase
    end

    // Frame capture, validation result and one-cycle pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            word_q       <= 48'h0;
            err_q        <= 1'b0;
            cfg_update_q <= 1'b0;
            frame_err_q  <= 1'b0;
            err_cnt_q    <= 16'h0;
        end else begin
            if (latch_en) word_q <= spi_rdata[47:0];
            if (in_check) err_q <= frame_bad;
            cfg_update_q <= wr_en;
            frame_err_q  <= in_check & frame_bad;
            if (in_check && frame_bad && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    // Control registers; a register-5 write overrides a coincident watchdog expiry
    always_ff @(posedge clk) begin
        if (reset) begin
            rx1_q   <= 32'h0;
            rx2_q   <= 32'h0;
            tx_q    <= 32'h0;
            drive_q <= 8'h0;
            att_q   <= 5'h0;
            ptt_q   <= 1'b0;
            gpio_q  <= 8'h0;
        end else begin
            if (wr_en && addr_w == 8'd0) rx1_q   <= data_w;
            if (wr_en && addr_w == 8'd1) rx2_q   <= data_w;
            if (wr_en && addr_w == 8'd2) tx_q    <= data_w;
            if (wr_en && addr_w == 8'd3) drive_q <= data_w[7:0];
            if (wr_en && addr_w == 8'd4) att_q   <= data_w[4:0];
            if (wr_en && addr_w == 8'd6) gpio_q  <= data_w[7:0];
            if (wr_ptt)        ptt_q <= data_w[0];
            else if (wdog_hit) ptt_q <= 1'b0;
        end
    end

    // Sticky status flags; a new event outranks a clearing status read
    always_ff @(posedge clk) begin
        if (reset) begin
            ovr_q       <= 1'b0;
            wdog_trip_q <= 1'b0;
        end else begin
            if (done_rise && state_q != S_IDLE) ovr_q <= 1'b1;
            else if (in_resp && status_rd)      ovr_q <= 1'b0;
            if (wdog_hit && !wr_ptt)            wdog_trip_q <= 1'b1;
            else if (in_resp && status_rd)      wdog_trip_q <= 1'b0;
        end
    end

    // PTT watchdog: held at zero while PTT is off and on every accepted frame
    always_ff @(posedge clk) begin
        if (reset)                 wdog_cnt_q <= 24'h0;
        else if (!ptt_q || accept) wdog_cnt_q <= 24'h0;
        else                       wdog_cnt_q <= wdog_cnt_q + 24'd1;
    end

    // Response word for the next frame
    always_ff @(posedge clk) begin
        if (reset)        tdata_q <= 48'h0;
        else if (in_resp) tdata_q <= {addr_w, ptt_q, err_q, seq_w, rd_val};
    end

    assign spi_tdata   = tdata_q;
    assign rx1_freq    = rx1_q;
    assign rx2_freq    = rx2_q;
    assign tx_freq     = tx_q;
    assign drive_level = drive_q;
    assign att         = att_q;
    assign ptt         = ptt_q;
    assign gpio_out    = gpio_q;
    assign cfg_update  = cfg_update_q;
    assign frame_err   = frame_err_q;
endmodule
